// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the decode-stage stall controller: FSM states and the
// kind of control transfer being resolved.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    CWAIT  = 2'd2,
    CLEAR  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    CALL   = 2'd1,
    RET    = 2'd2,
    BRANCH = 2'd3
  } ctl_type_e;

  localparam int unsigned WAIT_W = 8;

  // A decode slot can flag several kinds at once; call wins, then ret, then branch.
  function automatic ctl_type_e pick_type(input logic call, input logic ret, input logic branch);
    if (call)        return CALL;
    else if (ret)    return RET;
    else if (branch) return BRANCH;
    else             return NONE;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Width-parameterised saturating up-counter; holds at all-ones instead of wrapping.
// Async active-low reset to zero.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Turns hazard-detector outputs into PC/IF-ID/ID-EX stall, bubble, flush and
// redirect controls, and sequences control-hazard clears back to the detector.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CWAIT = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_hazard,
  input  logic             control_hazard,
  input  logic             call,
  input  logic             ret,
  input  logic             branch,
  input  logic             resolve,
  input  logic             taken,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pc_redirect,
  output logic             clr_call_haz,
  output logic             clr_ret_haz,
  output logic             clr_branch_haz,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_CWAIT - 1);

  state_e            state_q, state_d;
  ctl_type_e         type_q, type_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              holdoff_q, holdoff_d;
  logic              taken_q, taken_d;
  logic              timeout_q, timeout_d;
  logic              ctl_go;

  logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_bubble_c;
  logic pc_redirect_c, clr_call_c, clr_ret_c, clr_branch_c;

  // The detector keeps control_hazard high for a cycle after our clear; holdoff masks it.
  assign ctl_go = control_hazard && !holdoff_q;

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    wait_cnt_d = wait_cnt_q;
    taken_d    = taken_q;
    timeout_d  = timeout_q;
    holdoff_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ctl_go) begin
          state_d    = CWAIT;
          type_d     = pick_type(call, ret, branch);
          wait_cnt_d = '0;
        end else if (data_hazard) begin
          state_d = DSTALL;
        end
      end
      DSTALL: begin
        if (control_hazard) begin
          state_d    = CWAIT;
          type_d     = pick_type(call, ret, branch);
          wait_cnt_d = '0;
        end else if (!data_hazard) begin
          state_d = RUN;
        end
      end
      CWAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (resolve) begin
          state_d = CLEAR;
          taken_d = taken;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = CLEAR;
          taken_d   = 1'b0;
          timeout_d = 1'b1;
        end
      end
      CLEAR: begin
        state_d   = RUN;
        holdoff_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      type_q     <= NONE;
      wait_cnt_q <= '0;
      holdoff_q  <= 1'b0;
      taken_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      wait_cnt_q <= wait_cnt_d;
      holdoff_q  <= holdoff_d;
      taken_q    <= taken_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    pc_redirect_c  = 1'b0;
    clr_call_c     = 1'b0;
    clr_ret_c      = 1'b0;
    clr_branch_c   = 1'b0;
    unique case (state_q)
      RUN: begin
        pc_stall_c     = !ctl_go && data_hazard;
        if_id_stall_c  = !ctl_go && data_hazard;
        id_ex_bubble_c = !ctl_go && data_hazard;
      end
      DSTALL: begin
        pc_stall_c     = data_hazard;
        if_id_stall_c  = data_hazard;
        id_ex_bubble_c = data_hazard;
      end
      CWAIT: begin
        pc_stall_c    = 1'b1;
        if_id_flush_c = 1'b1;
      end
      CLEAR: begin
        pc_stall_c = 1'b1;
        unique case (type_q)
          CALL:    begin clr_call_c   = 1'b1; pc_redirect_c = 1'b1;    end
          RET:     begin clr_ret_c    = 1'b1; pc_redirect_c = 1'b1;    end
          BRANCH:  begin clr_branch_c = 1'b1; pc_redirect_c = taken_q; end
          default: begin
            clr_call_c   = 1'b1;
            clr_ret_c    = 1'b1;
            clr_branch_c = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  // Gating with rst forces every control low for the whole reset window, not just after an edge.
  assign pc_stall       = rst & pc_stall_c;
  assign if_id_stall    = rst & if_id_stall_c;
  assign if_id_flush    = rst & if_id_flush_c;
  assign id_ex_bubble   = rst & id_ex_bubble_c;
  assign pc_redirect    = rst & pc_redirect_c;
  assign clr_call_haz   = rst & clr_call_c;
  assign clr_ret_haz    = rst & clr_ret_c;
  assign clr_branch_haz = rst & clr_branch_c;
  assign timeout_err    = timeout_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (pc_stall),
    .cnt_o  (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random hazard traffic,
// checked every cycle against a flag/age based behavioural model.
module tb_pipe_stall_ctrl;

  localparam int MAXW  = 8;
  localparam int CW    = 5;
  localparam int SATV  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic data_hazard = 1'b0, control_hazard = 1'b0;
  logic call = 1'b0, ret = 1'b0, branch = 1'b0, resolve = 1'b0, taken = 1'b0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pc_redirect;
  logic clr_call_haz, clr_ret_haz, clr_branch_haz, timeout_err;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipe_stall_ctrl #(.MAX_CWAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .data_hazard(data_hazard), .control_hazard(control_hazard),
    .call(call), .ret(ret), .branch(branch), .resolve(resolve), .taken(taken),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pc_redirect(pc_redirect),
    .clr_call_haz(clr_call_haz), .clr_ret_haz(clr_ret_haz), .clr_branch_haz(clr_branch_haz),
    .timeout_err(timeout_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: flags for "waiting on EX", "clear cycle", "data stall", age of the wait, kind 0..3
  bit m_wait, m_clear, m_dstall, m_hold, m_tk, m_to;
  int m_age, m_kind, m_stalls;
  bit e_pc, e_st, e_fl, e_bub, e_rd, e_cc, e_cr, e_cb;
  bit seen_cc, seen_cb;

  task automatic model_reset();
    m_wait = 0; m_clear = 0; m_dstall = 0; m_hold = 0; m_tk = 0; m_to = 0;
    m_age = 0; m_kind = 0; m_stalls = 0;
  endtask

  task automatic model_expect();
    bit none_k;
    {e_pc, e_st, e_fl, e_bub, e_rd, e_cc, e_cr, e_cb} = '0;
    none_k = (m_kind == 0);
    if (m_clear) begin
      e_pc = 1;
      e_cc = none_k || m_kind == 1;
      e_cr = none_k || m_kind == 2;
      e_cb = none_k || m_kind == 3;
      e_rd = (m_kind == 1) || (m_kind == 2) || (m_kind == 3 && m_tk);
    end else if (m_wait) begin
      e_pc = 1; e_fl = 1;
    end else if (m_dstall) begin
      e_pc = data_hazard; e_st = data_hazard; e_bub = data_hazard;
    end else if (!(control_hazard && !m_hold) && data_hazard) begin
      e_pc = 1; e_st = 1; e_bub = 1;
    end
  endtask

  task automatic enter_wait();
    m_wait = 1; m_dstall = 0; m_age = 0;
    m_kind = call ? 1 : ret ? 2 : branch ? 3 : 0;
  endtask

  task automatic model_advance();
    bit was_hold;
    was_hold = m_hold;
    m_hold = 0;
    if (m_clear) begin
      m_clear = 0; m_hold = 1;
    end else if (m_wait) begin
      if (resolve) begin
        m_wait = 0; m_clear = 1; m_tk = taken;
      end else if (m_age == MAXW - 1) begin
        m_wait = 0; m_clear = 1; m_tk = 0; m_to = 1;
      end else begin
        m_age++;
      end
    end else if (m_dstall) begin
      if (control_hazard) enter_wait();
      else if (!data_hazard) m_dstall = 0;
    end else begin
      if (control_hazard && !was_hold) enter_wait();
      else if (data_hazard) m_dstall = 1;
    end
    if (e_pc && m_stalls < SATV) m_stalls++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_expect();
    check("pc_stall", 32'(pc_stall), 32'(e_pc));
    check("if_id_stall", 32'(if_id_stall), 32'(e_st));
    check("if_id_flush", 32'(if_id_flush), 32'(e_fl));
    check("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
    check("pc_redirect", 32'(pc_redirect), 32'(e_rd));
    check("clr_call", 32'(clr_call_haz), 32'(e_cc));
    check("clr_ret", 32'(clr_ret_haz), 32'(e_cr));
    check("clr_branch", 32'(clr_branch_haz), 32'(e_cb));
    check("timeout_err", 32'(timeout_err), 32'(m_to));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
    seen_cc = clr_call_haz;
    seen_cb = clr_branch_haz;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit dh, input bit ch, input bit c, input bit r, input bit b,
                       input bit res, input bit tk);
    data_hazard = dh; control_hazard = ch; call = c; ret = r; branch = b;
    resolve = res; taken = tk;
    tick();
  endtask

  task automatic do_reset();
    rst = 0;
    {data_hazard, control_hazard, call, ret, branch, resolve, taken} = '0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1;
  endtask

  task automatic branch_case(input bit tk);
    int ncb;
    ncb = 0;
    drive(0, 1, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 1, 1, tk);
    drive(0, 1, 0, 0, 1, 0, 0);
    ncb += int'(seen_cb);
    check(tk ? "br_taken_redirect" : "br_nt_redirect", 32'(pc_redirect), 32'(0));
    drive(0, 0, 0, 0, 0, 0, 0);
    check("br_clr_once", 32'(ncb), 32'(1));
  endtask

  initial begin
    int found;
    // Reset state, with hazards driven to show the reset masks them
    #2;
    data_hazard = 1; control_hazard = 1;
    #1;
    check("rst_pc_stall", 32'(pc_stall), 32'(0));
    check("rst_bubble", 32'(id_ex_bubble), 32'(0));
    check("rst_stall_cycles", 32'(stall_cycles), 32'(0));
    check("rst_timeout", 32'(timeout_err), 32'(0));
    do_reset();

    // Data hazard held 4 cycles
    repeat (4) drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("dstall_count", 32'(stall_cycles), 32'(4));

    // Call resolved 3 cycles after entry; detector holds control_hazard through holdoff
    do_reset();
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 1, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    check("call_clr_pulse", 32'(seen_cc), 32'(1));
    drive(0, 1, 1, 0, 0, 0, 0);
    check("call_no_reentry", 32'(seen_cc), 32'(0));
    drive(0, 0, 0, 0, 0, 0, 0);

    // Branch not taken / taken
    do_reset();
    branch_case(0);
    branch_case(1);

    // Simultaneous data and control hazard from RUN
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Timeout: branch never resolved
    do_reset();
    drive(0, 1, 0, 0, 1, 0, 0);
    found = 0;
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (seen_cb) begin
        found = i;
        break;
      end
    end
    check("timeout_clear_cycle", 32'(found), 32'(9));
    repeat (5) drive(0, 0, 0, 0, 0, 0, 0);
    check("timeout_sticky", 32'(timeout_err), 32'(1));

    // Asynchronous reset in the middle of CWAIT
    do_reset();
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 0;
    #1;
    check("arst_pc_stall", 32'(pc_stall), 32'(0));
    check("arst_flush", 32'(if_id_flush), 32'(0));
    check("arst_stall_cycles", 32'(stall_cycles), 32'(0));
    check("arst_timeout", 32'(timeout_err), 32'(0));
    @(posedge clk);
    #1;
    model_reset();
    rst = 1;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Random traffic; long enough for the narrow counter to saturate
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 2, $urandom_range(0, 1) == 1);
    end
    check("sat_reached", 32'(stall_cycles), 32'(SATV));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
